sfx_tone_player: RTL

- Downstream consumer of the sound-control register outputs (`selection[5:0]`, `reset`) of the APB game peripheral.
- Turns a trigger on a selection line into a short square-wave sound effect: a sequence of up to 4 notes read from a constant table, driven on a 1-bit audio pin (speaker/RC filter).
- Lets the game play hit/miss/life-lost effects without CPU timing involvement.

---
 rtl/sfx_pkg.sv | 54 +++++
 rtl/sfx_divider.sv | 34 +++
 rtl/sfx_tone_player.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sfx_pkg.sv
// Shared types, widths and the effect table for the sound-effect player.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Each effect is up to four steps of {hp, dur}. hp is a half-period in
// units of (1 << HP_SHIFT) PCLK cycles, hp == 0 is a rest. dur is a length
// in duration ticks, dur == 0 terminates the effect early.
package sfx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY
    } state_t;

    localparam int HP_W      = 12;
    localparam int DUR_W     = 8;
    localparam int HP_CNT_W  = 18;
    localparam int N_EFFECTS = 6;
    localparam int N_STEPS   = 4;

    localparam logic [2:0] NO_EFFECT = 3'd7;

    typedef struct packed {
        logic [HP_W-1:0]  hp;
        logic [DUR_W-1:0] dur;
    } step_t;

    localparam step_t EFFECT_TABLE [0:N_EFFECTS-1][0:N_STEPS-1] = '{
        // 0: tile hit
        '{'{12'd4,   8'd2}, '{12'd0,   8'd1}, '{12'd8,   8'd2}, '{12'd0,   8'd0}},
        // 1: miss
        '{'{12'd16,  8'd3}, '{12'd0,   8'd0}, '{12'd0,   8'd0}, '{12'd0,   8'd0}},
        // 2: life lost
        '{'{12'd40,  8'd3}, '{12'd60,  8'd3}, '{12'd90,  8'd4}, '{12'd0,   8'd0}},
        // 3: bonus (uses all four steps)
        '{'{12'd10,  8'd2}, '{12'd8,   8'd2}, '{12'd6,   8'd2}, '{12'd4,   8'd3}},
        // 4: level start
        '{'{12'd30,  8'd5}, '{12'd0,   8'd2}, '{12'd30,  8'd5}, '{12'd0,   8'd0}},
        // 5: game over
        '{'{12'd120, 8'd4}, '{12'd160, 8'd4}, '{12'd200, 8'd6}, '{12'd0,   8'd0}}
    };

    // Index of the lowest set bit; lowest trigger line has priority.
    function automatic logic [2:0] lowest_index(input logic [5:0] t);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (t[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sfx_divider.sv
// Reloadable down-counter with a one-cycle terminal pulse.
// Latency: tc asserts combinationally while enabled with count == 1; period = reload_val cycles.
// Backpressure: none; load has priority over counting.
//
// Ports: PCLK/PRESERN clock and sync active-low reset; load forces count to
// reload_val; en advances the count; tc is the terminal pulse (count reloads
// on the same edge, so the count never reaches 0 while running).
module sfx_divider #(
    parameter int W = 8
) (
    input  logic         PCLK,
    input  logic         PRESERN,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] reload_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    assign tc = en && (cnt == W'(1));

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload_val;
        end else if (en) begin
            if (cnt == W'(1)) cnt <= reload_val;
            else              cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/sfx_tone_player.sv
// Plays a short square-wave effect selected by a falling edge on a trigger line.
// Latency: busy/effect_id valid one edge after the trigger edge is seen; first toggle hp<<HP_SHIFT cycles into PLAY.
// Backpressure: none; a new trigger preempts the current effect, snd_reset mutes and blocks triggers.
//
// Ports: PCLK clock, PRESERN sync active-low reset, sel_n[5:0] active-low
// triggers, snd_reset active-high stop, audio_out 1-bit audio, busy playing
// flag, effect_id playing effect index (NO_EFFECT when idle).
module sfx_tone_player
    import sfx_pkg::*;
#(
    parameter int MS_DIV   = 100000,
    parameter int HP_SHIFT = 6
) (
    input  logic       PCLK,
    input  logic       PRESERN,
    input  logic [5:0] sel_n,
    input  logic       snd_reset,
    output logic       audio_out,
    output logic       busy,
    output logic [2:0] effect_id
);

    localparam int MS_W = $clog2(MS_DIV + 1);

    state_t             state;
    logic [5:0]         sel_n_q;
    logic [5:0]         trig;
    logic [2:0]         eff;
    logic [1:0]         step;
    logic [DUR_W-1:0]   dur_cnt;
    step_t              cur;
    logic [HP_CNT_W-1:0] hp_period;
    logic               hp_tc;
    logic               ms_tc;
    logic               cnt_load;
    logic               cnt_en;

    // Falling edges only; snd_reset masks them while sel_n_q keeps tracking,
    // so a line pulled low during mute does not fire on release.
    assign trig = sel_n_q & ~sel_n & {6{~snd_reset}};

    assign cur = EFFECT_TABLE[eff][step];

    // Rests still run the half-period counter, so give it a period of 1
    // instead of 0 to avoid wrapping; audio is not toggled for rests.
    assign hp_period = (cur.hp == '0) ? HP_CNT_W'(1)
                                      : (HP_CNT_W'(cur.hp) << HP_SHIFT);

    assign cnt_load = (state == ST_LOAD);
    assign cnt_en   = (state == ST_PLAY);

    sfx_divider #(.W(HP_CNT_W)) u_hp_div (
        .PCLK       (PCLK),
        .PRESERN    (PRESERN),
        .load       (cnt_load),
        .en         (cnt_en),
        .reload_val (hp_period),
        .tc         (hp_tc)
    );

    sfx_divider #(.W(MS_W)) u_ms_div (
        .PCLK       (PCLK),
        .PRESERN    (PRESERN),
        .load       (cnt_load),
        .en         (cnt_en),
        .reload_val (MS_W'(MS_DIV)),
        .tc         (ms_tc)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            state     <= ST_IDLE;
            sel_n_q   <= 6'b111111;
            eff       <= 3'd0;
            step      <= 2'd0;
            dur_cnt   <= '0;
            audio_out <= 1'b0;
            busy      <= 1'b0;
            effect_id <= NO_EFFECT;
        end else begin
            sel_n_q <= sel_n;
            if (snd_reset) begin
                state     <= ST_IDLE;
                audio_out <= 1'b0;
                busy      <= 1'b0;
                effect_id <= NO_EFFECT;
            end else if (|trig) begin
                // Start or preempt: restart from step 0 of the new effect.
                state     <= ST_LOAD;
                eff       <= lowest_index(trig);
                step      <= 2'd0;
                audio_out <= 1'b0;
                busy      <= 1'b1;
                effect_id <= lowest_index(trig);
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_LOAD: begin
                        audio_out <= 1'b0;
                        if (cur.dur == '0) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            effect_id <= NO_EFFECT;
                        end else begin
                            dur_cnt <= cur.dur;
                            state   <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (hp_tc && (cur.hp != '0)) audio_out <= ~audio_out;
                        if (ms_tc) begin
                            if (dur_cnt == DUR_W'(1)) begin
                                if (step == 2'd3) begin
                                    state     <= ST_IDLE;
                                    audio_out <= 1'b0;
                                    busy      <= 1'b0;
                                    effect_id <= NO_EFFECT;
                                end else begin
                                    step  <= step + 2'd1;
                                    state <= ST_LOAD;
                                end
                            end else begin
                                dur_cnt <= dur_cnt - DUR_W'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
